// File: rtl/btn_event_ctrl.sv
// Debounced push-button event controller: per-channel synchronizer and debouncer,
// press-event pending flags and a round-robin arbiter with a valid/ready output.
module btn_event_ctrl #(
  parameter int N         = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [$clog2(N)-1:0] evt_id,
  output logic [N-1:0]         pending,
  output logic [N-1:0]         overrun
);

  localparam int         IDW    = $clog2(N);
  localparam logic [7:0] DB_MAX = 8'(DB_CYCLES - 1);

  // Round-robin pick: returns {found, index}; search starts just after last.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0]   req,
                                           input logic [IDW-1:0] last);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int off = N; off >= 1; off--) begin
      idx = (int'(last) + off) % N;
      if (req[idx]) begin
        res = {1'b1, IDW'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [N-1:0]   sync1_q, sync2_q;
  logic [N-1:0]   db_q, db_d;
  logic [7:0]     cnt_q [N];
  logic [7:0]     cnt_d [N];
  logic [N-1:0]   press_s;

  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   overrun_q, overrun_d;
  logic           evt_valid_q, evt_valid_d;
  logic [IDW-1:0] evt_id_q, evt_id_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;

  logic           free_s;
  logic           grant_s;
  logic [IDW:0]   pick_s;
  logic [IDW-1:0] grant_idx_s;
  logic [N-1:0]   grant_mask_s;

  // Two-flop synchronizer on the raw asynchronous inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a level is accepted only after DB_CYCLES consecutive differing samples.
  always_comb begin
    db_d    = db_q;
    press_s = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] >= DB_MAX) begin
        db_d[i]    = sync2_q[i];
        cnt_d[i]   = 8'd0;
        press_s[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Debounced level and stability counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Arbiter and output stage; a new press on the granted channel re-arms it.
  always_comb begin
    free_s       = !evt_valid_q || evt_ready;
    pick_s       = rr_pick(pending_q, last_grant_q);
    grant_s      = free_s && pick_s[IDW];
    grant_idx_s  = pick_s[IDW-1:0];
    grant_mask_s = '0;
    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    last_grant_d = last_grant_q;

    if (grant_s) begin
      grant_mask_s[grant_idx_s] = 1'b1;
      evt_valid_d               = 1'b1;
      evt_id_d                  = grant_idx_s;
      last_grant_d              = grant_idx_s;
    end else if (free_s) begin
      evt_valid_d = 1'b0;
    end else begin
      evt_valid_d = evt_valid_q;
    end

    pending_d = (pending_q & ~grant_mask_s) | press_s;
    overrun_d = overrun_q | (press_s & pending_q & ~grant_mask_s);
  end

  // Event state registers; last_grant resets to N-1 so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      overrun_q    <= '0;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      last_grant_q <= IDW'(N - 1);
    end else begin
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed self-checking bench for btn_event_ctrl (N=4, DB_CYCLES=4).
module tb_btn_event_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [3:0] pending;
  logic [3:0] overrun;

  int total;
  int bad;

  btn_event_ctrl #(.N(4), .DB_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .pending   (pending),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One clean press/release of a channel (long enough to debounce both ways).
  task automatic pulse(input int ch);
    in[ch] = 1'b1;
    ticks(8);
    in[ch] = 1'b0;
    ticks(8);
  endtask

  initial begin
    int pulses;
    int viol;
    int stable;

    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in        = 4'b0000;
    evt_ready = 1'b1;

    // Reset state
    ticks(3);
    check_eq("rst_valid",   32'(evt_valid), 32'd0);
    check_eq("rst_id",      32'(evt_id),    32'd0);
    check_eq("rst_pending", 32'(pending),   32'd0);
    check_eq("rst_overrun", 32'(overrun),   32'd0);
    rst_n = 1'b1;
    ticks(3);

    // Round-robin from reset: ch0, ch2, ch3 together -> 0,2,3
    in = 4'b1101;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 5)  check_eq("rr_pend_early", 32'(pending), 32'h0);
      if (c == 6)  check_eq("rr_pend",       32'(pending), 32'hd);
      if (c == 7)  check_eq("rr_first",  32'({evt_valid, evt_id}), 32'h4);
      if (c == 8)  check_eq("rr_second", 32'({evt_valid, evt_id}), 32'h6);
      if (c == 9)  check_eq("rr_third",  32'({evt_valid, evt_id}), 32'h7);
      if (c == 10) check_eq("rr_idle",   32'(evt_valid), 32'd0);
    end
    in = 4'b0000;
    ticks(12);
    in = 4'b1001;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 6) check_eq("rr2_pend",   32'(pending), 32'h9);
      if (c == 7) check_eq("rr2_first",  32'({evt_valid, evt_id}), 32'h4);
      if (c == 8) check_eq("rr2_second", 32'({evt_valid, evt_id}), 32'h7);
      if (c == 9) check_eq("rr2_idle",   32'(evt_valid), 32'd0);
    end
    in = 4'b0000;
    ticks(12);

    // Single press on ch1 held 20 cycles; one pulse, none on release
    in[1]  = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (evt_valid) pulses++;
      if (c == 6) check_eq("sp_pend",   32'({evt_valid, pending}), 32'h02);
      if (c == 7) check_eq("sp_evt",    32'({evt_valid, evt_id}), 32'h5);
      if (c == 8) check_eq("sp_width",  32'(evt_valid), 32'd0);
    end
    check_eq("sp_pulses", 32'(pulses), 32'd1);
    in[1]  = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (evt_valid || pending != 4'b0000) pulses++;
    end
    check_eq("sp_release", 32'(pulses), 32'd0);

    // Glitch of 3 clocks on ch0 is rejected
    in[0] = 1'b1;
    ticks(3);
    in[0] = 1'b0;
    viol  = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (evt_valid || pending != 4'b0000) viol++;
    end
    check_eq("glitch", 32'(viol), 32'd0);

    // Backpressure on ch2 for 10 cycles
    evt_ready = 1'b0;
    in[2]     = 1'b1;
    ticks(7);
    check_eq("bp_present", 32'({evt_valid, evt_id}), 32'h6);
    stable = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (evt_valid && evt_id == 2'd2) stable++;
    end
    check_eq("bp_stable", 32'(stable), 32'd10);
    evt_ready = 1'b1;
    tick();
    check_eq("bp_drain", 32'(evt_valid), 32'd0);
    in[2] = 1'b0;
    ticks(12);

    // Overrun on ch1 under backpressure
    evt_ready = 1'b0;
    pulse(1);
    check_eq("ov_present", 32'({evt_valid, evt_id, pending}), 32'h50);
    pulse(1);
    check_eq("ov_pend",    32'({pending, overrun}), 32'h20);
    pulse(1);
    check_eq("ov_set",     32'({pending, overrun}), 32'h22);
    evt_ready = 1'b1;
    tick();
    check_eq("ov_regrant", 32'({evt_valid, evt_id, pending}), 32'h50);
    tick();
    check_eq("ov_once",    32'(evt_valid), 32'd0);
    check_eq("ov_sticky",  32'(overrun), 32'h2);

    // Async reset mid-cycle with evt_valid=1 and pending=1010
    evt_ready = 1'b0;
    in        = 4'b0001;
    ticks(8);
    in = 4'b1011;
    ticks(7);
    check_eq("ar_before", 32'({evt_valid, evt_id, pending}), 32'h4a);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("ar_clear", 32'({evt_valid, evt_id, pending, overrun}), 32'h000);
    ticks(2);
    evt_ready = 1'b1;
    rst_n     = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 5)  check_eq("ar_pend_early", 32'(pending), 32'h0);
      if (c == 6)  check_eq("ar_pend",       32'(pending), 32'hb);
      if (c == 7)  check_eq("ar_first",  32'({evt_valid, evt_id}), 32'h4);
      if (c == 8)  check_eq("ar_second", 32'({evt_valid, evt_id}), 32'h5);
      if (c == 9)  check_eq("ar_third",  32'({evt_valid, evt_id}), 32'h7);
      if (c == 10) check_eq("ar_idle",   32'(evt_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_event_ctrl.md
BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 Parameter N, default 4: number of asynchronous input channels (2..8).
REQ-002 Parameter DB_CYCLES, default 4: consecutive stable synchronized cycles required to accept a level change (1..255).
REQ-003 Port clk  input  1: single system clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port in  input  N: asynchronous raw inputs (buttons/switches), one per channel.
REQ-006 Port evt_valid  output  1: a press event is presented on evt_id.
REQ-007 Port evt_ready  input  1: consumer accepts the event when evt_valid and evt_ready are both 1 on a rising edge.
REQ-008 Port evt_id  output  $clog2(N): channel index of the presented event.
REQ-009 Port pending  output  N: per-channel press events waiting for grant.
REQ-010 Port overrun  output  N: sticky per-channel flag for a lost press event.

Function
REQ-011 Each in[i] SHALL pass through a two-flop synchronizer; the synchronized level s[i] equals in[i] as sampled two rising edges earlier.
REQ-012 Each channel SHALL hold a debounced level db[i] and a counter cnt[i] (8 bits).
REQ-013 When s[i]==db[i], cnt[i] SHALL clear to 0.
REQ-014 When s[i]!=db[i] and cnt[i]<DB_CYCLES-1, cnt[i] SHALL increment.
REQ-015 When s[i]!=db[i] and cnt[i]==DB_CYCLES-1, db[i] SHALL load s[i] and cnt[i] SHALL clear; a glitch shorter than DB_CYCLES synchronized cycles never changes db[i].
REQ-016 A press SHALL be the edge on which db[i] changes 0->1; on that same edge pending[i] SHALL set; 1->0 transitions generate no event.
REQ-017 Output stage is registered: evt_valid and evt_id change only on clock edges.
REQ-018 The output stage is free when evt_valid==0, or when evt_valid==1 and evt_ready==1 on that edge.
REQ-019 When the output stage is free and pending!=0, the arbiter SHALL grant one channel on that edge: evt_id<=granted index, evt_valid<=1, pending[granted]<=0.
REQ-020 Grant is round-robin: search starts at (last_grant+1) mod N and wraps; last_grant updates to the granted index.
REQ-021 When the output stage is free and pending==0, evt_valid SHALL go to 0.
REQ-022 While evt_valid==1 and evt_ready==0, evt_valid and evt_id SHALL hold stable.
REQ-023 Throughput: back-to-back grants are allowed, one event per cycle while evt_ready stays 1.
REQ-024 A press on channel i is lost when pending[i] is already 1 and channel i is not granted on that edge; in that case overrun[i] SHALL set, and pending[i] SHALL stay 1.
REQ-025 A press on channel i on the same edge that channel i is granted: the set wins, pending[i] stays 1, and overrun is not set.
REQ-026 overrun[i] SHALL clear only on reset.
REQ-027 Latency from DB_CYCLES=4: in[i] rising, first sampled at edge k -> db[i]=1 and pending[i]=1 after edge k+5 -> evt_valid=1 after edge k+6, if the output stage is free.

Reset
REQ-028 rst_n=0 SHALL immediately clear the following, independent of clk: sync flops, db, cnt, pending, overrun, evt_valid, evt_id, and last_grant=N-1 (so channel 0 is searched first).
REQ-029 Reset asserted mid-operation SHALL discard the presented and pending events without any handshake.
REQ-030 After rst_n deasserts, an input already held at 1 SHALL produce a press event after the same latency as REQ-027.

Verification
REQ-031 Single press: N=4, DB_CYCLES=4, in[1] 0->1 held 20 cycles, evt_ready=1 -> exactly one evt_valid pulse, evt_id=1, 6 edges after first sample, 1 cycle wide; no event on release.
REQ-032 Glitch reject: in[0] high for 3 clocks, then low -> db[0], pending and evt_valid stay 0 throughout.
REQ-033 Round-robin: presses on ch0, ch2 and ch3 become pending on the same edge, evt_ready=1 -> evt_id sequence 0,2,3 on consecutive cycles; a next simultaneous ch0+ch3 pair yields 0 then 3.
REQ-034 Backpressure: evt_ready=0 for 10 cycles with an event on ch2 -> evt_valid=1 and evt_id=2 stable all 10 cycles; raising evt_ready gives one accept, then evt_valid=0.
REQ-035 Overrun: evt_ready=0 with ch1 pending and ch1 presented; a second debounced press on ch1 -> overrun[1]=1 and stays 1 after drain; pending[1]=1 and delivers once.
REQ-036 Async reset: assert rst_n=0 between clock edges while evt_valid=1 and pending=4'b1010 -> all outputs 0 immediately; after release the first grant goes to ch0.
